// File: rtl/cnn_layer_scheduler_if.sv
// Handshake and configuration bundle between the layer scheduler (master)
// and the weight loader / shared layer engine (slave).
interface cnn_layer_scheduler_if #(
    parameter int unsigned CNT_W = 13,
    parameter int unsigned RES_W = 71
);
    logic                    wts_req;
    logic                    wts_ready;
    logic [2:0]              layer_id;
    logic [CNT_W-1:0]        cfg_out_len;
    logic                    cfg_pool;
    logic                    cfg_final;
    logic                    buf_sel;
    logic                    eng_start;
    logic                    eng_done;
    logic                    res_valid;
    logic signed [RES_W-1:0] res_data;

    modport master (
        output wts_req, layer_id, cfg_out_len, cfg_pool, cfg_final, buf_sel, eng_start,
        input  wts_ready, eng_done, res_valid, res_data
    );

    modport slave (
        input  wts_req, layer_id, cfg_out_len, cfg_pool, cfg_final, buf_sel, eng_start,
        output wts_ready, eng_done, res_valid, res_data
    );
endinterface

// File: rtl/cnn_layer_scheduler.sv
// Sequences conv1..dense2 on one shared engine and tracks the dense2 argmax.
// Optional RUN-state watchdog enabled by defining SCHED_WATCHDOG_EN.
module cnn_layer_scheduler #(
    parameter int unsigned NUM_LAYERS  = 5,
    parameter int unsigned RES_W       = 71,
    parameter int unsigned CNT_W       = 13,
    parameter int unsigned WDOG_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [4:0] class_out,
    output logic       err,
    output logic [1:0] err_code,
    cnn_layer_scheduler_if.master eng
);

    typedef enum logic [2:0] {StIdle, StLoad, StIssue, StRun, StNext} state_e;

    localparam logic [2:0]       LastLayer = 3'(NUM_LAYERS - 1);
    localparam logic [RES_W-1:0] MinScore  = {1'b1, {(RES_W-1){1'b0}}};

    if (WDOG_CYCLES == 0) begin : g_wdog_param_check
        $error("WDOG_CYCLES must be nonzero");
    end

    state_e                  state_q, state_d;
    logic [2:0]              layer_q, layer_d;
    logic                    buf_q, buf_d;
    logic [CNT_W-1:0]        beat_q, beat_d;
    logic signed [RES_W-1:0] best_val_q, best_val_d;
    logic [4:0]              best_idx_q, best_idx_d;
    logic [4:0]              class_q, class_d;
    logic                    err_q, err_d;
    logic [1:0]              err_code_q, err_code_d;

    logic [CNT_W-1:0]        cfg_len;
    logic                    cfg_pool_raw;
    logic                    is_final;

`ifdef SCHED_WATCHDOG_EN
    localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
    logic [WdogW-1:0] wdog_q, wdog_d;
`endif

    assign is_final = (layer_q == LastLayer);

    always_comb begin
        cfg_len      = CNT_W'(25);
        cfg_pool_raw = 1'b0;
        case (layer_q)
            3'd0: begin cfg_len = CNT_W'(5408); cfg_pool_raw = 1'b1; end
            3'd1: begin cfg_len = CNT_W'(1600); cfg_pool_raw = 1'b1; end
            3'd2: begin cfg_len = CNT_W'(128);  cfg_pool_raw = 1'b1; end
            3'd3: begin cfg_len = CNT_W'(512);  cfg_pool_raw = 1'b0; end
            default: begin cfg_len = CNT_W'(25); cfg_pool_raw = 1'b0; end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        buf_d      = buf_q;
        beat_d     = beat_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        class_d    = class_q;
        err_d      = err_q;
        err_code_d = err_code_q;
`ifdef SCHED_WATCHDOG_EN
        wdog_d     = wdog_q;
`endif

        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        err_d      = 1'b0;
                        err_code_d = 2'd0;
                        layer_d    = 3'd0;
                        buf_d      = 1'b0;
                        state_d    = StLoad;
                    end
                end
                StLoad: begin
                    if (eng.wts_ready) state_d = StIssue;
                end
                StIssue: begin
                    beat_d = '0;
                    if (is_final) begin
                        best_val_d = MinScore;
                        best_idx_d = 5'd0;
                    end
`ifdef SCHED_WATCHDOG_EN
                    wdog_d = '0;
`endif
                    state_d = StRun;
                end
                StRun: begin
                    if (eng.res_valid) begin
                        beat_d = beat_q + CNT_W'(1);
                        // Strict compare keeps the lower index on ties; overrun beats are ignored.
                        if (is_final && (beat_q < cfg_len) &&
                            ($signed(eng.res_data) > best_val_q)) begin
                            best_val_d = eng.res_data;
                            best_idx_d = beat_q[4:0];
                        end
                    end
`ifdef SCHED_WATCHDOG_EN
                    wdog_d = wdog_q + WdogW'(1);
`endif
                    if (eng.eng_done) begin
                        if (beat_d == cfg_len) begin
                            state_d = StNext;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = 2'd1;
                            state_d    = StIdle;
                        end
                    end
`ifdef SCHED_WATCHDOG_EN
                    else if (wdog_q == WdogW'(WDOG_CYCLES - 1)) begin
                        err_d      = 1'b1;
                        err_code_d = 2'd2;
                        state_d    = StIdle;
                    end
`endif
                end
                StNext: begin
                    if (is_final) begin
                        class_d = best_idx_q;
                        state_d = StIdle;
                    end else begin
                        layer_d = layer_q + 3'd1;
                        buf_d   = ~buf_q;
                        state_d = StLoad;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            layer_q    <= 3'd0;
            buf_q      <= 1'b0;
            beat_q     <= '0;
            best_val_q <= '0;
            best_idx_q <= 5'd0;
            class_q    <= 5'd0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            layer_q    <= layer_d;
            buf_q      <= buf_d;
            beat_q     <= beat_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            class_q    <= class_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

`ifdef SCHED_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wdog_q <= '0;
        else        wdog_q <= wdog_d;
    end
`endif

    // The result is presented alongside the done pulse; an abort in that cycle suppresses both.
    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StNext) && is_final && !abort;
    assign class_out = done ? best_idx_q : class_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

    assign eng.wts_req     = (state_q == StLoad);
    assign eng.eng_start   = (state_q == StIssue);
    assign eng.layer_id    = layer_q;
    assign eng.buf_sel     = buf_q;
    assign eng.cfg_out_len = busy ? cfg_len : '0;
    assign eng.cfg_pool    = busy & cfg_pool_raw;
    assign eng.cfg_final   = busy & is_final;

endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// Directed bench for cnn_layer_scheduler with a per-layer configuration scoreboard.
module tb_cnn_layer_scheduler;
    localparam int RES_W = 71;
    localparam int CNT_W = 13;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, err;
    logic [4:0] class_out;
    logic [1:0] err_code;

    cnn_layer_scheduler_if #(.CNT_W(CNT_W), .RES_W(RES_W)) bus ();

    cnn_layer_scheduler #(
        .NUM_LAYERS (5),
        .RES_W      (RES_W),
        .CNT_W      (CNT_W),
        .WDOG_CYCLES(20)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .class_out(class_out),
        .err      (err),
        .err_code (err_code),
        .eng      (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        int layer;
        int bsel;
        int len;
        int pool;
        int fin;
    } exp_t;

    exp_t sb[$];
    int   lens[5]  = '{5408, 1600, 128, 512, 25};
    int   pools[5] = '{1, 1, 1, 0, 0};
    int   scores[25];
    int   n_assert = 0;
    int   n_fail = 0;
    int   n_eng_start = 0;
    int   n_done = 0;
    int   es0, nd0;

    always @(posedge clk) begin
        if (bus.eng_start) n_eng_start <= n_eng_start + 1;
        if (done)          n_done <= n_done + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_inference();
        for (int l = 0; l < 5; l++) sb.push_back('{l, l % 2, lens[l], pools[l], (l == 4)});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for the ISSUE cycle and compare the issued configuration.
    task automatic wait_issue(input string tag);
        exp_t e;
        int   k = 0;
        while (!bus.eng_start && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_issue_seen"}, bus.eng_start, 1);
        if (bus.eng_start) begin
            check({tag, "_sb_nonempty"}, (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({tag, "_layer_id"}, bus.layer_id, e.layer);
                check({tag, "_buf_sel"}, bus.buf_sel, e.bsel);
                check({tag, "_cfg_out_len"}, bus.cfg_out_len, e.len);
                check({tag, "_cfg_pool"}, bus.cfg_pool, e.pool);
                check({tag, "_cfg_final"}, bus.cfg_final, e.fin);
            end
        end
    endtask

    // Starts from the ISSUE negedge; the last beat carries eng_done.
    task automatic send_beats(input int n, input bit use_scores);
        logic signed [RES_W-1:0] v;
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            v             = use_scores ? scores[i] : 0;
            bus.res_valid = 1'b1;
            bus.res_data  = v;
            bus.eng_done  = (i == n - 1);
            @(negedge clk);
        end
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        bus.eng_done  = 1'b0;
    endtask

    task automatic full_inference(input string tag, input int exp_class);
        es0 = n_eng_start;
        nd0 = n_done;
        for (int l = 0; l < 5; l++) begin
            wait_issue(tag);
            send_beats(lens[l], (l == 4));
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_class_out"}, class_out, exp_class);
        @(negedge clk);
        check({tag, "_done_cleared"}, done, 0);
        check({tag, "_idle"}, busy, 0);
        check({tag, "_class_held"}, class_out, exp_class);
        check({tag, "_eng_starts"}, n_eng_start - es0, 5);
        check({tag, "_done_pulses"}, n_done - nd0, 1);
    endtask

    initial begin
        int k;
        bus.wts_ready = 1'b1;
        bus.eng_done  = 1'b0;
        bus.res_valid = 1'b0;
        bus.res_data  = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, done, class_out, err, err_code, bus.wts_req, bus.eng_start,
                                bus.layer_id, bus.cfg_out_len, bus.cfg_pool, bus.cfg_final,
                                bus.buf_sel}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Nominal: peak of 100 at index 17.
        for (int i = 0; i < 25; i++) scores[i] = 2 * i;
        scores[17] = 100;
        push_inference();
        pulse_start();
        check("nom_busy", busy, 1);
        check("nom_wts_req", bus.wts_req, 1);
        full_inference("nom", 17);

        // Ties and negatives: lower index wins.
        for (int i = 0; i < 25; i++) scores[i] = -7;
        scores[4] = -3;
        scores[9] = -3;
        push_inference();
        pulse_start();
        full_inference("tie", 4);

        // conv2 one beat short.
        nd0 = n_done;
        push_inference();
        pulse_start();
        wait_issue("mis");
        send_beats(lens[0], 1'b0);
        wait_issue("mis");
        send_beats(1599, 1'b0);
        check("mis_err", err, 1);
        check("mis_err_code", err_code, 1);
        check("mis_busy", busy, 0);
        check("mis_class_kept", class_out, 4);
        check("mis_no_done", n_done - nd0, 0);
        sb.delete();

        // Abort during conv3 RUN.
        push_inference();
        pulse_start();
        check("abt_err_cleared", err, 0);
        check("abt_code_cleared", err_code, 0);
        nd0 = n_done;
        for (int l = 0; l < 2; l++) begin
            wait_issue("abt");
            send_beats(lens[l], 1'b0);
        end
        wait_issue("abt");
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            bus.res_valid = 1'b1;
            @(negedge clk);
        end
        bus.res_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abt_busy", busy, 0);
        check("abt_err", err, 0);
        check("abt_class_kept", class_out, 4);
        check("abt_no_done", n_done - nd0, 0);
        sb.delete();

        // Stalled weights, start during RUN, then peak at the last index.
        for (int i = 0; i < 25; i++) scores[i] = 1;
        scores[24] = 1000;
        bus.wts_ready = 1'b0;
        es0 = n_eng_start;
        push_inference();
        pulse_start();
        repeat (50) @(negedge clk);
        check("stall_wts_req", bus.wts_req, 1);
        check("stall_no_eng_start", n_eng_start - es0, 0);
        bus.wts_ready = 1'b1;
        wait_issue("ign");
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_layer_id", bus.layer_id, 0);
        check("ign_busy", busy, 1);
        send_beats(lens[0], 1'b0);
        nd0 = n_done;
        for (int l = 1; l < 5; l++) begin
            wait_issue("ign");
            send_beats(lens[l], (l == 4));
        end
        check("ign_done", done, 1);
        check("ign_class_out", class_out, 24);
        @(negedge clk);
        check("ign_eng_starts", n_eng_start - es0, 5);
        check("ign_done_pulses", n_done - nd0, 1);

        // Reset mid-dense1.
        push_inference();
        pulse_start();
        for (int l = 0; l < 3; l++) begin
            wait_issue("rst");
            send_beats(lens[l], 1'b0);
        end
        wait_issue("rst");
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.res_valid = 1'b1;
            @(negedge clk);
        end
        bus.res_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_outputs", {busy, done, class_out, err, err_code, bus.wts_req, bus.eng_start,
                              bus.layer_id, bus.cfg_out_len, bus.cfg_pool, bus.cfg_final,
                              bus.buf_sel}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);

        // Engine never finishes.
        push_inference();
        pulse_start();
        wait_issue("wdg");
`ifdef SCHED_WATCHDOG_EN
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 100);
        check("wdg_cycles_to_idle", k, 21);
        check("wdg_err", err, 1);
        check("wdg_err_code", err_code, 2);
`else
        k = 0;
        repeat (1000) @(negedge clk);
        check("nowdg_busy", busy, 1);
        check("nowdg_err", err, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("nowdg_abort_idle", busy, 0);
`endif
        sb.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/cnn_layer_scheduler.md
Name: cnn_layer_scheduler

Overview:
- Sequences the five-layer sign classifier (conv1, conv2, conv3, dense1, dense2) on one shared layer engine, one layer at a time.
- Per layer: waits for the weight loader, issues the layer configuration and a start pulse, counts result beats until the engine reports done, and toggles the ping-pong activation buffer.
- During dense2, tracks the argmax of the 25 scores and presents the class index.

Parameters:
- NUM_LAYERS, 5, layers per inference; fixed table order conv1, conv2, conv3, dense1, dense2.
- RES_W, 71, signed result width on the engine result bus.
- CNT_W, 13, beat counter width; holds 5408.
- WDOG_CYCLES, 1000000, RUN-state timeout, used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  inference request; sampled only in IDLE
- abort  in  1  return to IDLE at the next edge
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when an inference completes
- class_out  out  5  argmax index of the dense2 scores, 0..24
- err  out  1  sticky error flag; cleared by the next accepted start
- err_code  out  2  0 none, 1 beat mismatch, 2 watchdog
- wts_req  out  1  request to load weights for layer_id
- wts_ready  in  1  weights for layer_id are resident
- layer_id  out  3  current layer, 0..4
- cfg_out_len  out  CNT_W  expected result beats for layer_id
- cfg_pool  out  1  ReLU plus 2x2 max-pool enable (conv layers)
- cfg_final  out  1  layer_id==4; selects raw output, no ReLU
- buf_sel  out  1  ping-pong buffer read by the engine; it writes the other buffer
- eng_start  out  1  one-cycle engine start pulse
- eng_done  in  1  engine finished the layer
- res_valid  in  1  result beat valid
- res_data  in  RES_W  signed result value

Behaviour:
- Reset values: every output 0; state IDLE; counters 0.
- Config table, indexed by layer_id:
  - cfg_out_len: 5408, 1600, 128, 512, 25.
  - cfg_pool: 1, 1, 1, 0, 0.
- IDLE:
  - start=1: clear err and err_code, set layer_id=0 and buf_sel=0, go to LOAD.
- LOAD:
  - wts_req=1 while in this state.
  - wts_ready=1: go to ISSUE. Minimum 1 cycle in LOAD.
- ISSUE:
  - eng_start=1 for exactly this cycle; clear beat_cnt.
  - If layer_id==4, also clear best_val to the most-negative value and best_idx to 0.
  - Always go to RUN next.
- RUN:
  - Each res_valid: beat_cnt increments.
  - If layer_id==4 and res_data > best_val (signed, strict): best_val=res_data, best_idx=beat_cnt. Ties keep the lower index.
  - Beats after beat_cnt reaches cfg_out_len: counted, not compared.
  - res_valid and eng_done together: count the beat first, then evaluate done.
  - eng_done=1, count correct: go to NEXT.
  - eng_done=1, final beat_cnt != cfg_out_len: err=1, err_code=1, go to IDLE. No done pulse; class_out unchanged.
- NEXT:
  - If layer_id<4: layer_id+1, toggle buf_sel, go to LOAD.
  - Else: class_out=best_idx, done=1 for this cycle, go to IDLE.
- Timing: with zero-latency wts_ready and engine, one layer is LOAD, ISSUE, RUN (one cycle or more), NEXT; at least 4 cycles.
- class_out holds its value until the next successful completion.
- abort: from any state, go to IDLE at the next edge with busy=0. No done, no err change, class_out unchanged.
- abort and start in the same IDLE cycle: abort wins, start ignored.
- start while busy: ignored.
- eng_done or res_valid outside RUN: ignored.
- rst_n low mid-inference: immediate return to reset values; an engine pulse already issued is not retracted.

Optional Feature:
- Macro SCHED_WATCHDOG_EN.
- Defined:
  - A counter clears on entering RUN and increments every RUN cycle.
  - Reaching WDOG_CYCLES without eng_done: err=1, err_code=2, go to IDLE.
- Undefined: no counter; RUN waits indefinitely; err_code 2 is never produced.

Test Plan:
- Nominal run: start; wts_ready immediate; engine returns 5408, 1600, 128, 512 beats, then 25 beats with score 100 at index 17, all others <=50 → layer_id steps 0..4, buf_sel 0,1,0,1,0, exactly five eng_start pulses, done pulse, class_out=17.
- Tie and negatives: dense2 scores all -7 except -3 at indices 4 and 9 → class_out=4.
- Beat mismatch: conv2 returns 1599 beats then eng_done → err=1, err_code=1, busy=0, no done, class_out retains its previous value.
- Abort and reset: abort during conv3 RUN → IDLE next cycle, busy=0, err=0. A new start then runs a full inference normally. rst_n low mid-dense1 → all outputs 0 at once.
- Wait and ignore: wts_ready held low 50 cycles in LOAD → wts_req stays high, no eng_start. start pulsed during RUN → no effect.
- Watchdog (SCHED_WATCHDOG_EN, WDOG_CYCLES=20): engine never asserts eng_done → err_code=2 after 20 RUN cycles. Without the macro, still busy after 1000 cycles.
